// File: rtl/testharnass_modmul_top.sv
// -----------------------------------------------------------------------------
// testharnass_modmul_top
//
// Self-contained bring-up harness around one modular multiplier. After reset
// it forms the full product OP_A*OP_B, reduces it modulo MODULUS with a
// single-cycle Barrett reducer, compares the residue against EXPECTED and
// raises done. There are no stimulus inputs; the operands are elaboration-time
// constants.
//
// Ports:
//   clk   in   1  single clock, all logic on its rising edge
//   rst   in   1  synchronous, active-high reset
//   done  out  1  registered; high once the result is computed and checked,
//                 held until the next reset
//
// Internal registers kept under fixed names for hierarchical observation:
//   state, prod (2*WIDTH bits), result (WIDTH bits), match (1 bit)
// -----------------------------------------------------------------------------
module testharnass_modmul_top #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned MODULUS  = 65521,
   parameter int unsigned OP_A     = 12345,
   parameter int unsigned OP_B     = 54321,
   parameter int unsigned EXPECTED = 50831
) (
   input  logic clk,
   input  logic rst,
   output logic done
);

   localparam int unsigned PW = 2 * WIDTH;

   // 2^(2*WIDTH) needs one bit more than the product width.
   localparam logic [PW:0]   LP_POW = {1'b1, {PW{1'b0}}};
   // Barrett constant mu = floor(2^(2*WIDTH) / M); M > 1 keeps it within PW bits.
   localparam logic [PW-1:0] LP_MU  = PW'(LP_POW / (PW + 1)'(MODULUS));
   localparam logic [PW-1:0] LP_M   = PW'(MODULUS);

   typedef enum logic [1:0] {
      S_MUL  = 2'd0,
      S_RED  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            w_state_nxt;
   logic [PW-1:0]     prod;
   logic [WIDTH-1:0]  result;
   logic              match;

   logic [PW-1:0]     w_prod_full;
   logic [2*PW-1:0]   w_est;
   logic [PW-1:0]     w_q;
   logic [PW-1:0]     w_qm;
   logic [PW-1:0]     w_r0;
   logic [PW-1:0]     w_r1;
   logic [PW-1:0]     w_r2;
   logic [WIDTH-1:0]  w_red;
   logic              w_match;

   // Full-width constant product, no truncation.
   always_comb begin
      w_prod_full = PW'(OP_A) * PW'(OP_B);
   end

   // Barrett reduction of prod. Since prod < 2^(2*WIDTH) the quotient estimate
   // is at most one short, so the two trailing conditional subtractions leave
   // the residue in [0, M-1] with margin.
   always_comb begin
      w_est = {{PW{1'b0}}, prod} * {{PW{1'b0}}, LP_MU};
      w_q   = PW'(w_est >> PW);
      // q*M never exceeds prod, so the low PW bits hold the exact product.
      w_qm  = w_q * LP_M;
      w_r0  = prod - w_qm;
      if (w_r0 >= LP_M) begin
         w_r1 = w_r0 - LP_M;
      end else begin
         w_r1 = w_r0;
      end
      if (w_r1 >= LP_M) begin
         w_r2 = w_r1 - LP_M;
      end else begin
         w_r2 = w_r1;
      end
      w_red   = WIDTH'(w_r2);
      w_match = (w_red == WIDTH'(EXPECTED));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_MUL;
      end else begin
         state <= w_state_nxt;
      end
   end

   // Next-state logic: MUL -> RED -> DONE, DONE is terminal until reset.
   always_comb begin
      w_state_nxt = state;
      case (state)
         S_MUL:   w_state_nxt = S_RED;
         S_RED:   w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_MUL;
      endcase
   end

   // Datapath registers and the registered done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod   <= '0;
         result <= '0;
         match  <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            S_MUL: begin
               prod <= w_prod_full;
            end
            S_RED: begin
               result <= w_red;
               match  <= w_match;
               // done is raised regardless of match; match is diagnostic.
               done   <= 1'b1;
            end
            S_DONE: begin
               prod <= prod;
            end
            default: begin
               prod <= prod;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_testharnass_modmul_top.sv
// -----------------------------------------------------------------------------
// tb_testharnass_modmul_top
//
// Drives only rst (fixed scenarios plus randomized pulse/run lengths) into
// five differently parameterised harness instances and compares done, prod,
// result and match every cycle against a behavioural model: the expected
// values come from plain 64-bit arithmetic on the parameters and a count of
// reset-free edges since the last reset.
// -----------------------------------------------------------------------------
module tb_testharnass_modmul_top;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic done_def, done_zero, done_max, done_mis, done_w8;

   testharnass_modmul_top u_def (
      .clk(clk), .rst(rst), .done(done_def)
   );

   testharnass_modmul_top #(
      .WIDTH(16), .MODULUS(65521), .OP_A(0), .OP_B(54321), .EXPECTED(0)
   ) u_zero (
      .clk(clk), .rst(rst), .done(done_zero)
   );

   testharnass_modmul_top #(
      .WIDTH(16), .MODULUS(65521), .OP_A(65520), .OP_B(65520), .EXPECTED(1)
   ) u_max (
      .clk(clk), .rst(rst), .done(done_max)
   );

   testharnass_modmul_top #(
      .WIDTH(16), .MODULUS(65521), .OP_A(65520), .OP_B(2), .EXPECTED(0)
   ) u_mis (
      .clk(clk), .rst(rst), .done(done_mis)
   );

   testharnass_modmul_top #(
      .WIDTH(8), .MODULUS(251), .OP_A(200), .OP_B(250), .EXPECTED(51)
   ) u_w8 (
      .clk(clk), .rst(rst), .done(done_w8)
   );

   // Model: number of consecutive rising edges with rst low, saturating.
   int m_cnt = 0;
   always @(posedge clk) begin
      m_cnt <= rst ? 0 : ((m_cnt >= 3) ? 3 : m_cnt + 1);
   end

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_inst(input string nm, input logic d, input logic [63:0] p,
                             input logic [63:0] r, input logic mt,
                             input longint unsigned a, input longint unsigned b,
                             input longint unsigned mod, input longint unsigned ex);
      longint unsigned pv;
      longint unsigned rv;
      pv = a * b;
      rv = pv % mod;
      check_eq({nm, ".done"},   64'(d),  64'(m_cnt >= 2));
      check_eq({nm, ".prod"},   p,       (m_cnt >= 1) ? 64'(pv) : 64'd0);
      check_eq({nm, ".result"}, r,       (m_cnt >= 2) ? 64'(rv) : 64'd0);
      check_eq({nm, ".match"},  64'(mt), (m_cnt >= 2) ? 64'(rv == ex) : 64'd0);
   endtask

   task automatic check_all();
      check_inst("def",  done_def,  64'(u_def.prod),  64'(u_def.result),  u_def.match,
                 12345, 54321, 65521, 50831);
      check_inst("zero", done_zero, 64'(u_zero.prod), 64'(u_zero.result), u_zero.match,
                 0, 54321, 65521, 0);
      check_inst("max",  done_max,  64'(u_max.prod),  64'(u_max.result),  u_max.match,
                 65520, 65520, 65521, 1);
      check_inst("mis",  done_mis,  64'(u_mis.prod),  64'(u_mis.result),  u_mis.match,
                 65520, 2, 65521, 0);
      check_inst("w8",   done_w8,   64'(u_w8.prod),   64'(u_w8.result),   u_w8.match,
                 200, 250, 251, 51);
   endtask

   // n cycles: check at each falling edge, then set rst for the next rising edge.
   task automatic run(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_all();
         rst = lvl;
      end
   endtask

   initial begin
      rst = 1'b1;
      run(1'b1, 8);      // reset held
      run(1'b0, 102);    // release, complete, hold for 100 cycles
      run(1'b1, 1);      // one-cycle reset while in DONE
      run(1'b0, 12);
      run(1'b1, 1);
      run(1'b0, 1);      // one edge out of reset -> RED
      run(1'b1, 1);      // reset hits in RED
      run(1'b0, 10);
      run(1'b1, 20);     // long reset
      for (int k = 0; k < 40; k++) begin
         run(1'b0, int'($urandom_range(0, 5)));
         run(1'b1, int'($urandom_range(1, 3)));
      end
      run(1'b0, 6);
      @(negedge clk);
      check_all();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
